// File: rtl/note_game_ctrl.sv
// note_game_ctrl
// Round sequencer for the "memory" game mode. Each round it advances the
// random-note LFSR once, appends the new note to an internal sequence
// buffer, plays the whole sequence back through the tone generator and then
// checks the player's key presses against it.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   start        one-cycle pulse, starts a new game from IDLE/WIN/LOSE
//   rand_note    current LFSR output (0..11)
//   Enable_rand  one-cycle advance strobe to the LFSR
//   key_valid    one-cycle key press pulse
//   key_note     note index of the pressed key
//   play_en      tone generator enable during playback
//   play_note    note to sound while play_en=1
//   level        current sequence length
//   busy         high while a game is in progress
//   pass         held high after a won game
//   fail         held high after a lost game
module note_game_ctrl #(
  parameter int MAX_LEN  = 8,
  parameter int NOTE_CYC = 25000000,
  parameter int GAP_CYC  = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] rand_note,
  output logic       Enable_rand,
  input  logic       key_valid,
  input  logic [3:0] key_note,
  output logic       play_en,
  output logic [3:0] play_note,
  output logic [3:0] level,
  output logic       busy,
  output logic       pass,
  output logic       fail
);

  localparam int MAX_CYC = (NOTE_CYC > GAP_CYC) ? NOTE_CYC : GAP_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] NOTE_LD = TW'(NOTE_CYC - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYC - 1);
  localparam logic [3:0]    MAX_LEN_4 = 4'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE, GEN, CAPT, PLAY, GAP, WAIT, WIN, LOSE
  } state_t;

  state_t          state_reg;
  logic [3:0]      len_reg;
  logic [3:0]      idx_reg;
  logic [TW-1:0]   timer_reg;
  logic [3:0]      seq [MAX_LEN];

  logic [3:0]      idx_plus;
  logic [3:0]      cur_note;
  logic [3:0]      nxt_note;
  logic            last_idx;

  assign idx_plus = idx_reg + 4'd1;
  assign last_idx = (idx_plus == len_reg);
  assign level    = len_reg;

  // Read muxes for seq[idx] and seq[idx+1]; out-of-range indices read 0.
  always_comb begin
    cur_note = 4'd0;
    nxt_note = 4'd0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (idx_reg == 4'(i))  cur_note = seq[i];
      if (idx_plus == 4'(i)) nxt_note = seq[i];
    end
  end

  // Sequence buffer: one new note appended per round, written only in CAPT.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_LEN; i++) begin
      if (state_reg == CAPT && len_reg == 4'(i)) seq[i] <= rand_note;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      len_reg     <= 4'd0;
      idx_reg     <= 4'd0;
      timer_reg   <= '0;
      Enable_rand <= 1'b0;
      play_en     <= 1'b0;
      play_note   <= 4'd0;
      busy        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
    end else begin
      Enable_rand <= 1'b0;
      case (state_reg)
        IDLE, WIN, LOSE: begin
          if (start) begin
            len_reg     <= 4'd0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            busy        <= 1'b1;
            Enable_rand <= 1'b1;
            state_reg   <= GEN;
          end
        end
        GEN: state_reg <= CAPT;
        CAPT: begin
          len_reg   <= len_reg + 4'd1;
          idx_reg   <= 4'd0;
          play_en   <= 1'b1;
          // seq[0] is being written this same edge in the first round
          play_note <= (len_reg == 4'd0) ? rand_note : seq[0];
          timer_reg <= NOTE_LD;
          state_reg <= PLAY;
        end
        PLAY: begin
          if (timer_reg == '0) begin
            play_en   <= 1'b0;
            play_note <= 4'd0;
            timer_reg <= GAP_LD;
            state_reg <= GAP;
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        GAP: begin
          if (timer_reg == '0) begin
            if (last_idx) begin
              idx_reg   <= 4'd0;
              state_reg <= WAIT;
            end else begin
              idx_reg   <= idx_plus;
              play_en   <= 1'b1;
              play_note <= nxt_note;
              timer_reg <= NOTE_LD;
              state_reg <= PLAY;
            end
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        WAIT: begin
          if (key_valid) begin
            if (key_note != cur_note) begin
              fail      <= 1'b1;
              busy      <= 1'b0;
              state_reg <= LOSE;
            end else if (!last_idx) begin
              idx_reg <= idx_plus;
            end else if (len_reg == MAX_LEN_4) begin
              pass      <= 1'b1;
              busy      <= 1'b0;
              state_reg <= WIN;
            end else begin
              Enable_rand <= 1'b1;
              state_reg   <= GEN;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_game_ctrl.sv
module tb_note_game_ctrl;

  localparam int MAX_LEN  = 3;
  localparam int NOTE_CYC = 4;
  localparam int GAP_CYC  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] rand_note;
  logic       enable_rand;
  logic       key_valid;
  logic [3:0] key_note;
  logic       play_en;
  logic [3:0] play_note;
  logic [3:0] level;
  logic       busy;
  logic       pass;
  logic       fail;

  int errors = 0;
  int checks = 0;
  int game_notes [MAX_LEN];

  always #5 clk = ~clk;

  note_game_ctrl #(
    .MAX_LEN (MAX_LEN),
    .NOTE_CYC(NOTE_CYC),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rand_note  (rand_note),
    .Enable_rand(enable_rand),
    .key_valid  (key_valid),
    .key_note   (key_note),
    .play_en    (play_en),
    .play_note  (play_note),
    .level      (level),
    .busy       (busy),
    .pass       (pass),
    .fail       (fail)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Plays one game against the model. The model is simply the list of notes
  // the LFSR produced; every round the expected playback is the whole list
  // so far, each note NOTE_CYC cycles on then GAP_CYC cycles silent.
  // bad_round < 0 means the player never errs; bad_key < 0 picks a random
  // wrong key. noise injects ignored start/key pulses.
  task automatic run_game(input int bad_round, input int bad_pos,
                          input int bad_key, input bit noise);
    int len = 0;
    int k_exp;
    int k_drv;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_pass_clr", pass, 0);
    chk("start_fail_clr", fail, 0);
    for (int r = 0; r < MAX_LEN; r++) begin
      chk("gen_en", enable_rand, 1);
      chk("gen_busy", busy, 1);
      chk("gen_level", level, len);
      rand_note = 4'(game_notes[r]);
      step();
      chk("capt_en", enable_rand, 0);
      chk("capt_play", play_en, 0);
      len++;
      for (int i = 0; i < len; i++) begin
        for (int c = 0; c < NOTE_CYC; c++) begin
          step();
          key_valid = 1'b0;
          start = 1'b0;
          chk("play_en", play_en, 1);
          chk("play_note", play_note, game_notes[i]);
          chk("play_level", level, len);
          chk("play_rand", enable_rand, 0);
          if (noise && c == 1) begin
            key_valid = 1'b1;
            key_note = 4'($urandom_range(0, 11));
            start = 1'b1;
          end
        end
        for (int c = 0; c < GAP_CYC; c++) begin
          step();
          key_valid = 1'b0;
          start = 1'b0;
          chk("gap_en", play_en, 0);
          chk("gap_note", play_note, 0);
          chk("gap_fail", fail, 0);
          if (noise && c == 0) begin
            key_valid = 1'b1;
            key_note = 4'($urandom_range(0, 11));
          end
        end
      end
      step();
      key_valid = 1'b0;
      start = 1'b0;
      chk("wait_play", play_en, 0);
      chk("wait_busy", busy, 1);
      chk("wait_level", level, len);
      if (noise) begin
        start = 1'b1;
        step();
        start = 1'b0;
        chk("wait_start_rand", enable_rand, 0);
        chk("wait_start_level", level, len);
        chk("wait_start_busy", busy, 1);
      end
      for (int k = 0; k < len; k++) begin
        k_exp = game_notes[k];
        if (r == bad_round && k == bad_pos)
          k_drv = (bad_key >= 0) ? bad_key : (k_exp + 1 + $urandom_range(0, 10)) % 12;
        else
          k_drv = k_exp;
        key_valid = 1'b1;
        key_note = 4'(k_drv);
        step();
        key_valid = 1'b0;
        if (k_drv != k_exp) begin
          chk("lose_fail", fail, 1);
          chk("lose_busy", busy, 0);
          chk("lose_pass", pass, 0);
          chk("lose_level", level, len);
          key_valid = 1'b1;
          key_note = 4'(k_exp);
          step();
          key_valid = 1'b0;
          step();
          chk("lose_held", fail, 1);
          chk("lose_idle_rand", enable_rand, 0);
          $display("game: lost round %0d at key %0d (key %0d, expected %0d)", r + 1, k, k_drv, k_exp);
          return;
        end else if (k < len - 1) begin
          chk("key_ok_busy", busy, 1);
          chk("key_ok_rand", enable_rand, 0);
          chk("key_ok_fail", fail, 0);
        end else if (len == MAX_LEN) begin
          chk("win_pass", pass, 1);
          chk("win_busy", busy, 0);
          chk("win_level", level, MAX_LEN);
          key_valid = 1'b1;
          key_note = 4'($urandom_range(0, 11));
          step();
          key_valid = 1'b0;
          step();
          chk("win_held", pass, 1);
          chk("win_fail", fail, 0);
          chk("win_level_held", level, MAX_LEN);
          $display("game: won with notes %0d %0d %0d", game_notes[0], game_notes[1], game_notes[2]);
          return;
        end
      end
      $display("round %0d complete, level %0d", r + 1, len);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    rand_note = 4'd0;
    key_valid = 1'b0;
    key_note = 4'd0;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);
    chk("rst_play", play_en, 0);
    chk("rst_note", play_note, 0);
    chk("rst_rand", enable_rand, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);

    // Asynchronous reset in the middle of playback.
    start = 1'b1;
    step();
    start = 1'b0;
    rand_note = 4'd7;
    step();
    step();
    chk("pre_rst_play", play_en, 1);
    chk("pre_rst_note", play_note, 7);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_play", play_en, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_level", level, 0);
    chk("async_rst_rand", enable_rand, 0);
    #2 reset = 1'b0;
    $display("async reset mid-playback done");

    // Directed full win: 5, 9, 0.
    game_notes = '{5, 9, 0};
    run_game(-1, 0, -1, 1'b1);
    // Directed loss: round 2, keys 5 then 3.
    game_notes = '{5, 9, 0};
    run_game(1, 1, 3, 1'b1);

    for (int g = 0; g < 8; g++) begin
      for (int i = 0; i < MAX_LEN; i++) game_notes[i] = $urandom_range(0, 11);
      if ($urandom_range(0, 2) == 0)
        run_game(-1, 0, -1, 1'($urandom_range(0, 1)));
      else begin
        int br = $urandom_range(0, MAX_LEN - 1);
        run_game(br, $urandom_range(0, br), -1, 1'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
